// File: rtl/kgp_minirisc_ctrl_fsm.sv
// Multi-cycle control FSM for a small RISC core: FETCH/DECODE/EXEC/MEM/WB with HALT and ERR sinks.
// Latency FETCH-to-FETCH 2..5 cycles plus memory waits; requests hold until acked or until the wait counter expires.
module kgp_minirisc_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       branch_taken,
    input  logic       if_ack,
    input  logic       mem_ack,
    output logic       if_req,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       reg_we,
    output logic       alu_src_imm,
    output logic       wb_sel,
    output logic       shamt_sel,
    output logic       halted,
    output logic       bus_err
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_R_ALU, C_I_ALU, C_LOAD, C_STORE, C_BRANCH, C_HALTOP
    } cls_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state, nxt_state;
    cls_t       cls, nxt_cls;
    logic [7:0] wait_cnt, nxt_cnt;
    logic       fetch_ack;
    logic       exec_branch;

    function automatic cls_t decode_op(input logic [5:0] op);
        cls_t c;
        casez (op)
            6'b010000: c = C_R_ALU;
            6'b000???: c = C_I_ALU;
            6'b100000: c = C_LOAD;
            6'b100001: c = C_STORE;
            6'b110???: c = C_BRANCH;
            6'b111111: c = C_HALTOP;
            default:   c = C_NOP;
        endcase
        return c;
    endfunction

    // The instruction fetch only counts once if_req is actually up, so the
    // first cycle after reset release neither accepts an ack nor ages the counter.
    assign fetch_ack   = (state == S_FETCH) && if_req && if_ack;
    assign exec_branch = (state == S_EXEC) && (cls == C_BRANCH) && branch_taken;
    assign ir_we       = fetch_ack;
    assign pc_we       = fetch_ack || exec_branch;
    assign pc_src      = exec_branch;

    always_comb begin
        nxt_state = state;
        nxt_cls   = cls;
        nxt_cnt   = wait_cnt;
        case (state)
            S_FETCH: begin
                if (if_req) begin
                    if (if_ack)                       nxt_state = S_DECODE;
                    else if (wait_cnt == TIMEOUT_CNT) nxt_state = S_ERR;
                    else                              nxt_cnt   = wait_cnt + 8'd1;
                end
            end
            S_DECODE: begin
                nxt_cls = decode_op(opcode);
                case (nxt_cls)
                    C_R_ALU, C_I_ALU, C_LOAD, C_STORE, C_BRANCH: nxt_state = S_EXEC;
                    C_HALTOP:                                    nxt_state = S_HALT;
                    default:                                     nxt_state = S_FETCH;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_R_ALU, C_I_ALU: nxt_state = S_WB;
                    C_LOAD, C_STORE:  nxt_state = S_MEM;
                    default:          nxt_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ack)                      nxt_state = (cls == C_LOAD) ? S_WB : S_FETCH;
                else if (wait_cnt == TIMEOUT_CNT) nxt_state = S_ERR;
                else                              nxt_cnt   = wait_cnt + 8'd1;
            end
            S_WB:    nxt_state = S_FETCH;
            default: nxt_state = state;
        endcase
        // Every state change restarts the wait window for the state being entered.
        if (nxt_state != state) nxt_cnt = 8'd0;
    end

    // Moore outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            cls         <= C_NOP;
            wait_cnt    <= 8'd0;
            if_req      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            reg_we      <= 1'b0;
            alu_src_imm <= 1'b0;
            wb_sel      <= 1'b0;
            shamt_sel   <= 1'b0;
            halted      <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state       <= nxt_state;
            cls         <= nxt_cls;
            wait_cnt    <= nxt_cnt;
            if_req      <= (nxt_state == S_FETCH);
            mem_rd      <= (nxt_state == S_MEM) && (nxt_cls == C_LOAD);
            mem_wr      <= (nxt_state == S_MEM) && (nxt_cls == C_STORE);
            reg_we      <= (nxt_state == S_WB);
            wb_sel      <= (nxt_state == S_WB) && (nxt_cls == C_LOAD);
            alu_src_imm <= (nxt_state == S_EXEC) &&
                           (nxt_cls inside {C_I_ALU, C_LOAD, C_STORE, C_BRANCH});
            shamt_sel   <= (nxt_state == S_EXEC) && (nxt_cls == C_R_ALU);
            halted      <= (nxt_state == S_HALT);
            bus_err     <= (nxt_state == S_ERR);
        end
    end

endmodule

// File: tb/tb_kgp_minirisc_ctrl_fsm.sv
// Scoreboard bench: directed instruction sequences push expected output vectors; a negedge monitor pops and compares.
module tb_kgp_minirisc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       branch_taken = 1'b0;
    logic       if_ack = 1'b0;
    logic       mem_ack = 1'b0;
    logic       if_req, mem_rd, mem_wr, ir_we, pc_we, pc_src;
    logic       reg_we, alu_src_imm, wb_sel, shamt_sel, halted, bus_err;
    logic [11:0] outs;

    kgp_minirisc_ctrl_fsm #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .if_ack(if_ack), .mem_ack(mem_ack), .if_req(if_req), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .alu_src_imm(alu_src_imm), .wb_sel(wb_sel),
        .shamt_sel(shamt_sel), .halted(halted), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign outs = {if_req, mem_rd, mem_wr, ir_we, pc_we, pc_src,
                   reg_we, alu_src_imm, wb_sel, shamt_sel, halted, bus_err};

    localparam logic [11:0] O_IF  = 12'h800, O_RD  = 12'h400, O_WR  = 12'h200;
    localparam logic [11:0] O_IR  = 12'h100, O_PW  = 12'h080, O_PS  = 12'h040;
    localparam logic [11:0] O_RW  = 12'h020, O_IMM = 12'h010, O_WBS = 12'h008;
    localparam logic [11:0] O_SH  = 12'h004, O_HLT = 12'h002, O_ERR = 12'h001;
    localparam logic [11:0] O_NONE = 12'h000;
    localparam logic [11:0] O_FETCH_ACK = O_IF | O_IR | O_PW;

    localparam logic [5:0] OP_RALU = 6'b010000, OP_IALU = 6'b000101;
    localparam logic [5:0] OP_LOAD = 6'b100000, OP_STORE = 6'b100001;
    localparam logic [5:0] OP_BR_T = 6'b110010, OP_BR_N = 6'b110111;
    localparam logic [5:0] OP_NOP = 6'b001000, OP_HALT = 6'b111111;

    typedef struct {
        logic [11:0] vec;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%03h want=%03h (if,rd,wr,ir,pcw,pcs,rw,imm,wbs,sh,hlt,err)",
                     name, got, want);
        end
    endtask

    // One clock cycle of stimulus; inputs change just after the edge so the
    // next edge samples them, and the expected outputs for this cycle are queued.
    task automatic step(input logic [5:0] op, input logic ia, input logic ma, input logic br,
                        input logic [11:0] want, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        opcode = op;
        if_ack = ia;
        mem_ack = ma;
        branch_taken = br;
        e.vec = want;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic reset_pulse(input string name);
        @(negedge clk);
        #2 rst_n = 1'b0;
        if_ack = 1'b0;
        mem_ack = 1'b0;
        #1 check(name, outs, O_NONE);
        #1 rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.name, outs, e.vec);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        #12 check("reset_state", outs, O_NONE);
        @(negedge clk);
        #4 rst_n = 1'b1;

        step(OP_RALU, 1, 0, 0, O_FETCH_ACK, "ralu_fetch");
        step(OP_RALU, 0, 0, 0, O_NONE,      "ralu_decode");
        step(OP_RALU, 0, 0, 0, O_SH,        "ralu_exec");
        step(OP_RALU, 0, 0, 0, O_RW,        "ralu_wb");

        step(OP_IALU, 1, 0, 0, O_FETCH_ACK, "ialu_fetch");
        step(OP_IALU, 0, 0, 0, O_NONE,      "ialu_decode");
        step(OP_IALU, 0, 0, 0, O_IMM,       "ialu_exec");
        step(OP_IALU, 0, 0, 0, O_RW,        "ialu_wb");

        step(OP_LOAD, 1, 0, 0, O_FETCH_ACK, "load_fetch");
        step(OP_LOAD, 0, 0, 0, O_NONE,      "load_decode");
        step(OP_LOAD, 0, 0, 0, O_IMM,       "load_exec");
        for (int i = 0; i < 3; i++)
            step(OP_LOAD, 0, 0, 0, O_RD, "load_mem_wait");
        step(OP_LOAD, 0, 1, 0, O_RD,        "load_mem_ack");
        step(OP_LOAD, 0, 0, 0, O_RW | O_WBS, "load_wb");

        step(OP_STORE, 1, 0, 0, O_FETCH_ACK, "store_fetch");
        step(OP_STORE, 0, 0, 0, O_NONE,      "store_decode");
        step(OP_STORE, 0, 0, 0, O_IMM,       "store_exec");
        step(OP_STORE, 0, 1, 0, O_WR,        "store_mem_ack");

        // Opcode changes during EXEC must not alter the latched class.
        step(OP_BR_T, 1, 0, 0, O_FETCH_ACK, "br_taken_fetch");
        step(OP_BR_T, 0, 0, 0, O_NONE,      "br_taken_decode");
        step(OP_RALU, 0, 0, 1, O_IMM | O_PW | O_PS, "br_taken_exec");

        step(OP_BR_N, 1, 0, 0, O_FETCH_ACK, "br_not_fetch");
        step(OP_BR_N, 0, 0, 0, O_NONE,      "br_not_decode");
        step(OP_BR_N, 0, 0, 0, O_IMM,       "br_not_exec");

        step(OP_NOP, 1, 0, 0, O_FETCH_ACK, "nop_fetch");
        step(OP_NOP, 1, 1, 1, O_NONE,      "nop_decode_stray_acks");

        for (int i = 0; i < 15; i++)
            step(OP_NOP, 0, 0, 0, O_IF, "to_ack_wait");
        step(OP_NOP, 1, 0, 0, O_FETCH_ACK, "to_ack_at_limit");
        step(OP_NOP, 0, 0, 0, O_NONE,      "to_ack_decode");

        for (int i = 0; i < 16; i++)
            step(OP_NOP, 0, 0, 0, O_IF, "to_err_wait");
        step(OP_NOP, 0, 0, 0, O_ERR, "err_enter");
        step(OP_NOP, 1, 1, 0, O_ERR, "err_sticky_acks");
        step(OP_NOP, 1, 0, 0, O_ERR, "err_sticky");
        reset_pulse("err_reset_async");

        step(OP_HALT, 1, 0, 0, O_FETCH_ACK, "halt_fetch");
        step(OP_HALT, 0, 0, 0, O_NONE,      "halt_decode");
        step(OP_HALT, 0, 0, 0, O_HLT,       "halt_enter");
        for (int i = 0; i < 20; i++)
            step(OP_RALU, 1'(i % 2), 1'(i % 3 == 0), 0, O_HLT, "halt_hold");
        reset_pulse("halt_reset_async");
        step(OP_NOP, 0, 0, 0, O_IF, "post_halt_fetch");

        step(OP_STORE, 1, 0, 0, O_FETCH_ACK, "rst_store_fetch");
        step(OP_STORE, 0, 0, 0, O_NONE,      "rst_store_decode");
        step(OP_STORE, 0, 0, 0, O_IMM,       "rst_store_exec");
        step(OP_STORE, 0, 0, 0, O_WR,        "rst_store_mem");
        step(OP_STORE, 0, 0, 0, O_WR,        "rst_store_mem_hold");
        reset_pulse("mid_mem_reset_async");
        step(OP_NOP, 0, 0, 0, O_IF, "post_rst_fetch");
        step(OP_NOP, 0, 0, 0, O_IF, "post_rst_no_regwe");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
